osram_drain: RTL and testbench

Read-side drain engine for the 128×32 output SRAM (`sram_32b_w128`). After the corelet has written psum results, this block reads a programmed window of words back out and presents them on a valid/ready stream with full backpressure. It drives the SRAM port with the corelet's conventions: 7-bit address, active-low CEN/WEN, read-only. It sits on the core-side output-SRAM port, muxed with the corelet under the core's select logic.

---
 rtl/osram_drain.sv | 167 ++++++++++++++++
 tb/tb_osram_drain.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/osram_drain.sv
// osram_drain: read-side drain engine for the 128x32 output SRAM.
// Reads a programmed window of words (base, length) and presents them on a
// valid/ready stream through a 2-entry FIFO. Read issue is throttled so that
// buffered words plus reads in flight never exceed the FIFO depth.
module osram_drain #(
  parameter int addr_bw = 7,
  parameter int data_bw = 32,
  parameter int depth   = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] base_a,
  input  logic [7:0]         len,
  output logic [addr_bw-1:0] O_A,
  output logic               O_CEN,
  output logic               O_WEN,
  input  logic [data_bw-1:0] O_Q,
  output logic [data_bw-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [7:0]         MAX_LEN  = 8'(depth);
  localparam logic [addr_bw-1:0] LAST_ADR = addr_bw'(depth - 1);

  // Control state
  logic [1:0]         state_q, state_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         issue_q, issue_d;
  logic [7:0]         xfer_q, xfer_d;
  logic [addr_bw-1:0] addr_q, addr_d;
  logic               done_q, done_d;
  logic               inflight_q;

  // Output FIFO
  logic [data_bw-1:0] mem_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         count_q;

  logic [7:0] len_clamped;
  logic [2:0] occupancy;
  logic       pop;
  logic       push;
  logic       issue;

  assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;

  assign pop  = (count_q != 2'd0) && out_ready;
  // Data on O_Q belongs to the read issued in the previous cycle.
  assign push = inflight_q;

  // Entries that will be buffered or pending after this cycle's transfer.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign issue = (state_q == S_RUN) && (issue_q != len_q) && (occupancy < 3'd2);

  assign O_CEN     = ~issue;
  assign O_A       = issue ? addr_q : '0;
  assign O_WEN     = 1'b1;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = done_q;

  // Next-state logic for the job FSM and its counters.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d = state_q;
    len_d   = len_q;
    issue_d = issue_q;
    xfer_d  = xfer_q;
    addr_d  = addr_q;
    done_d  = 1'b0;

    if (pop) begin
      xfer_d = xfer_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len_clamped;
          addr_d  = base_a;
          issue_d = 8'd0;
          xfer_d  = 8'd0;
          if (len_clamped == 8'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (issue) begin
          issue_d = issue_q + 8'd1;
          addr_d  = (addr_q == LAST_ADR) ? '0 : addr_q + 1'b1;
          if (issue_d == len_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Every read precedes its transfer, so the final transfer always
        // lands here rather than in RUN.
        if (pop && (xfer_d == len_q)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: state elements use non-blocking assignment so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!reset) begin
      state_q    <= S_IDLE;
      len_q      <= 8'd0;
      issue_q    <= 8'd0;
      xfer_q     <= 8'd0;
      addr_q     <= '0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issue_q    <= issue_d;
      xfer_q     <= xfer_d;
      addr_q     <= addr_d;
      done_q     <= done_d;
      inflight_q <= issue;
    end
  end

  // FIFO storage and pointers; captures O_Q the edge after each read.
  always_ff @(posedge clk) begin
    // NOTE: the two storage words are reset because out_data is the raw head
    // entry and must read 0 after reset; a deeper memory would not be.
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= O_Q;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_osram_drain.sv
// Self-checking bench for osram_drain: table-driven jobs plus hand-written
// reset-abort and reset-value sequences, against a behavioural SRAM model.
module tb_osram_drain;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  base_a;
  logic [7:0]  len;
  logic [6:0]  O_A;
  logic        O_CEN;
  logic        O_WEN;
  logic [31:0] O_Q;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  osram_drain #(.addr_bw(7), .data_bw(32), .depth(128)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_a    (base_a),
    .len       (len),
    .O_A       (O_A),
    .O_CEN     (O_CEN),
    .O_WEN     (O_WEN),
    .O_Q       (O_Q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency, garbage on O_Q when not read.
  logic [31:0] sram [128];
  logic [31:0] sram_q;
  assign O_Q = sram_q;
  always @(posedge clk) begin
    if (!O_CEN) sram_q <= sram[O_A];
    else        sram_q <= $urandom;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Ready pattern: mode 0 always ready, mode 1 repeats 1,0,0,1.
  int rmode = 0;
  always @(posedge clk) begin
    #1;
    if (rmode == 1) out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    else            out_ready = 1'b1;
  end

  // Monitor state (sampled mid-cycle, describes the coming edge).
  logic [31:0] xfer_log [$];
  logic [6:0]  iss_log  [$];
  int          viol, done_cnt, done_cyc, first_valid_cyc, last_xfer_cyc;
  bit          done_seen;
  int          m_entries, m_inflight;
  bit          prev_stall;
  logic [31:0] prev_data;

  always @(negedge clk) begin
    if (!reset) begin
      m_entries  = 0;
      m_inflight = 0;
      prev_stall = 1'b0;
    end else begin
      int x;
      x = (out_valid && out_ready) ? 1 : 0;
      if (!O_CEN) begin
        iss_log.push_back(O_A);
        if (m_entries + m_inflight - x >= 2) viol++;
      end else if (O_A != 7'd0) viol++;
      if (O_WEN !== 1'b1) viol++;
      if (out_valid !== (m_entries != 0)) viol++;
      if (prev_stall && (!out_valid || out_data !== prev_data)) viol++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (x == 1) begin
        xfer_log.push_back(out_data);
        last_xfer_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_seen = 1'b1;
        if (busy) viol++;
      end
      m_entries  = m_entries + m_inflight - x;
      m_inflight = O_CEN ? 0 : 1;
    end
  end

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    xfer_log.delete();
    iss_log.delete();
    viol = 0; done_cnt = 0; done_cyc = -1;
    first_valid_cyc = -1; last_xfer_cyc = -1; done_seen = 1'b0;
  endtask

  typedef struct {
    logic [6:0]  base;
    logic [7:0]  len;
    int          rmode;
    int          poke;      // loop index at which a second start is driven, -1 none
    int          exp_n;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    int          exp_last_off; // last transfer cycle minus start cycle, -1 unchecked
  } vec_t;

  vec_t vecs [7];
  int   start_cyc;

  task automatic run_job(input vec_t v);
    int err;
    rmode = v.rmode;
    @(posedge clk); #1;
    clear_logs();
    base_a = v.base; len = v.len; start = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    start = 1'b0; base_a = 7'h55; len = 8'h33;
    for (int k = 0; k < 1000 && !done_seen; k++) begin
      if (k == v.poke) begin
        start = 1'b1; base_a = 7'd99; len = 8'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("job_done_seen", {31'd0, done_seen}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("xfer_count", xfer_log.size(), v.exp_n);
    check("read_count", iss_log.size(), v.exp_n);
    err = 0;
    for (int i = 0; i < v.exp_n; i++) begin
      logic [6:0] a;
      a = 7'((int'(v.base) + i) % 128);
      if (i < iss_log.size()  && iss_log[i]  !== a) err++;
      if (i < xfer_log.size() && xfer_log[i] !== (32'hA500_0000 + 32'(a))) err++;
    end
    check("stream_order", err, 0);
    check("no_violations", viol, 0);
    check("done_pulses", done_cnt, 1);
    check("busy_idle_after", {31'd0, busy}, 32'd0);
    if (v.exp_n > 0) begin
      check("first_word", xfer_log[0], v.exp_first);
      check("last_word", xfer_log[v.exp_n-1], v.exp_last);
      check("first_valid_latency", first_valid_cyc - start_cyc, 2);
      check("done_after_last", done_cyc - last_xfer_cyc, 1);
    end else begin
      check("done_zero_len", done_cyc - start_cyc, 0);
    end
    if (v.exp_last_off >= 0)
      check("last_xfer_timing", last_xfer_cyc - start_cyc, v.exp_last_off);
  endtask

  initial begin
    for (int k = 0; k < 128; k++) sram[k] = 32'hA500_0000 + k;
    reset = 1'b0; start = 1'b0; base_a = '0; len = '0; out_ready = 1'b1;
    clear_logs();

    vecs[0] = '{7'd0,   8'd4,   0, -1, 4,   32'hA500_0000, 32'hA500_0003, 5};
    vecs[1] = '{7'd126, 8'd128, 0, -1, 128, 32'hA500_007E, 32'hA500_007D, 129};
    vecs[2] = '{7'd10,  8'd0,   0, -1, 0,   32'h0,         32'h0,         -1};
    vecs[3] = '{7'd50,  8'd200, 0, -1, 128, 32'hA500_0032, 32'hA500_0031, 129};
    vecs[4] = '{7'd120, 8'd16,  1, -1, 16,  32'hA500_0078, 32'hA500_0007, -1};
    vecs[5] = '{7'd3,   8'd10,  0, 10, 10,  32'hA500_0003, 32'hA500_000C, 11};
    vecs[6] = '{7'd127, 8'd1,   0, -1, 1,   32'hA500_007F, 32'hA500_007F, 2};

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cen", {31'd0, O_CEN}, 32'd1);
    check("rst_wen", {31'd0, O_WEN}, 32'd1);
    check("rst_addr", {25'd0, O_A}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 7; i++) run_job(vecs[i]);

    // Reset mid-job after three transfers.
    rmode = 0;
    @(posedge clk); #1;
    clear_logs();
    base_a = 7'd5; len = 8'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 100 && xfer_log.size() < 3; k++) begin
      @(posedge clk); #1;
    end
    check("abort_xfers_before", xfer_log.size(), 3);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_cen", {31'd0, O_CEN}, 32'd1);
    check("abort_addr", {25'd0, O_A}, 32'd0);
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_data", out_data, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_no_more_xfers", xfer_log.size(), 3);

    run_job('{7'd7, 8'd8, 0, -1, 8, 32'hA500_0007, 32'hA500_000E, 9});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
